add16_seq: RTL and testbench

ADD16_SEQ -- requirements
Module: add16_seq

---
 rtl/add_seq_pkg.sv | 11 +
 rtl/add16_seq_rca4.sv | 23 ++
 rtl/add16_seq.sv | 111 +++++++++++
 tb/tb_add16_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial adder.
package add_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/add16_seq_rca4.sv
// Combinational 4-bit ripple-carry adder: one nibble step of add16_seq.
module rca_4
  import add_seq_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             CIN,
  output logic [NIB_W-1:0] SUM,
  output logic             COUT
);

  always_comb begin
    logic w_cy;
    w_cy = CIN;
    SUM  = '0;
    for (int i = 0; i < NIB_W; i++) begin
      SUM[i] = A[i] ^ B[i] ^ w_cy;
      w_cy   = (A[i] & B[i]) | (w_cy & (A[i] ^ B[i]));
    end
    COUT = w_cy;
  end

endmodule

// File: rtl/add16_seq.sv
// Sequential adder: one nibble per cycle, done pulses NIB+1 cycles after start.
// start is ignored while busy; done and the next start may coincide.
module add16_seq
  import add_seq_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NIB_W*NIB-1:0] a,
  input  logic [NIB_W*NIB-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [NIB_W*NIB-1:0] sum,
  output logic                 cout
);

  localparam int W     = NIB_W * NIB;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic [IDX_W-1:0] r_idx;
  logic             r_cy;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [NIB_W-1:0] w_nib_a;
  logic [NIB_W-1:0] w_nib_b;
  logic [NIB_W-1:0] w_nib_sum;
  logic             w_nib_cout;
  logic             w_last;

  assign w_nib_a = r_a[r_idx*NIB_W +: NIB_W];
  assign w_nib_b = r_b[r_idx*NIB_W +: NIB_W];
  assign w_last  = (r_idx == LAST_IDX);

  rca_4 u_rca (
    .A    (w_nib_a),
    .B    (w_nib_b),
    .CIN  (r_cy),
    .SUM  (w_nib_sum),
    .COUT (w_nib_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_idx  <= '0;
      r_cy   <= 1'b0;
      r_cout <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_cy   <= cin;
            r_sum  <= '0;
            r_idx  <= '0;
            r_busy <= 1'b1;
          end
        end
        RUN: begin
          r_sum[r_idx*NIB_W +: NIB_W] <= w_nib_sum;
          r_cy <= w_nib_cout;
          // idx parks on the last nibble rather than wrapping
          if (w_last) begin
            r_cout <= w_nib_cout;
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_add16_seq.sv
// Scoreboard bench for add16_seq: expected {cout,sum} queued at start, checked on done.
module tb_add16_seq;
  localparam int NIB = 4;

  typedef struct {
    logic [16:0] res;
    int          k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   last_done = 0;
  int   prev_done = 0;
  exp_t sb[$];
  exp_t mon_e;

  add16_seq #(.NIB(NIB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", 32'({cout, sum}), 32'(mon_e.res));
        chk("latency", 32'(cyc - mon_e.k), 32'(NIB));
        chk("busy_len", 32'(busy_cnt), 32'(NIB));
      end
      busy_cnt  = 0;
      prev_done = last_done;
      last_done = cyc;
    end
  end

  // Leaves start high one edge after acceptance so callers can chain.
  task automatic op_start(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(busy), 32'd0);
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    sb.push_back('{res: {1'b0, ta} + {1'b0, tb_v} + 17'(tc), k: cyc + 1});
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    start = 1'b0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // carry ripples through every nibble
    op_start(16'hFFFF, 16'h0001, 1'b0);
    wait_idle();
    chk("ovf_sum",  32'(sum),  32'h0000);
    chk("ovf_cout", 32'(cout), 32'd1);

    op_start(16'h1234, 16'h4321, 1'b1);
    wait_idle();
    chk("cin_sum",  32'(sum),  32'h5556);
    chk("cin_cout", 32'(cout), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sum",  32'(sum),  32'h5556);
    chk("hold_cout", 32'(cout), 32'd0);

    // back-to-back: second start presented in the done cycle
    op_start(16'h8000, 16'h8000, 1'b0);
    op_start(16'h00FF, 16'h0001, 1'b0);
    wait_idle();
    chk("b2b_sum",  32'(sum),  32'h0100);
    chk("b2b_cout", 32'(cout), 32'd0);
    chk("b2b_gap",  32'(last_done - prev_done), 32'(NIB + 1));

    // start and operand changes during RUN must be ignored
    op_start(16'h1111, 16'h2222, 1'b0);
    start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    chk("ign_sum",  32'(sum),  32'h3333);
    chk("ign_cout", 32'(cout), 32'd0);

    // abort mid-operation
    op_start(16'h0F0F, 16'h0101, 1'b0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    op_start(16'hA5A5, 16'h5A5A, 1'b1);
    wait_idle();
    chk("post_abort_sum",  32'(sum),  32'h0000);
    chk("post_abort_cout", 32'(cout), 32'd1);

    for (int i = 0; i < 1000; i++) begin
      op_start(16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        start = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
